barrel_unshifter_pipe: RTL

// - Pipelined rotate-RIGHT unit: inverse of the datapath's combinational rotate-left barrel shifter.

---
 rtl/barrel_unshifter_pipe.sv | 91 +++++++++
 1 files changed

// File: rtl/barrel_unshifter_pipe.sv
// Pipelined rotate-right unit: stage s conditionally rotates right by 2**s.
// Valid/ready handshake with a combinational ready chain, so no bubbles are inserted.
module barrel_unshifter_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shifts,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shifts,
  output logic             busy
);

  // Handshake: a word moves across any boundary on a clock edge where the
  // upstream valid and the downstream ready are both high. A stage may load
  // when it is empty or when the stage after it is itself advancing.

  logic [SHW-1:0]   v;
  logic [WIDTH-1:0] d     [SHW];
  logic [SHW-1:0]   sh    [SHW];

  logic [SHW-1:0]   adv;
  logic [SHW-1:0]   up_v;
  logic [WIDTH-1:0] up_d  [SHW];
  logic [SHW-1:0]   up_sh [SHW];

  function automatic logic [WIDTH-1:0] rotr_stage(input logic [WIDTH-1:0] x,
                                                   input int s);
    int amt;
    amt = 1 << s;
    return (x >> amt) | (x << (WIDTH - amt));
  endfunction

  // Ready ripples from the output back to the input within one cycle.
  always_comb begin : ready_chain
    logic carry;
    carry = out_ready;
    adv   = '0;
    for (int s = SHW - 1; s >= 0; s--) begin
      adv[s] = ~v[s] | carry;
      carry  = adv[s];
    end
  end

  always_comb begin
    up_v = '0;
    for (int s = 0; s < SHW; s++) begin
      up_d[s]  = '0;
      up_sh[s] = '0;
    end
    up_v[0]  = in_valid;
    up_sh[0] = in_shifts;
    up_d[0]  = in_shifts[0] ? rotr_stage(in_data, 0) : in_data;
    for (int s = 1; s < SHW; s++) begin
      up_v[s]  = v[s-1];
      up_sh[s] = sh[s-1];
      up_d[s]  = sh[s-1][s] ? rotr_stage(d[s-1], s) : d[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int s = 0; s < SHW; s++) begin
        d[s]  <= '0;
        sh[s] <= '0;
      end
    end else begin
      for (int s = 0; s < SHW; s++) begin
        if (adv[s]) begin
          v[s]  <= up_v[s];
          d[s]  <= up_d[s];
          sh[s] <= up_sh[s];
        end
      end
    end
  end

  assign in_ready   = adv[0];
  assign out_valid  = v[SHW-1];
  assign out_data   = d[SHW-1];
  assign out_shifts = sh[SHW-1];
  assign busy       = |v;

endmodule
